// File: rtl/login_arb_pkg.sv
// Shared types and constants for the console login arbiter.
// Holds the arbiter FSM encoding, default parameter values and a width helper.
package login_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    SESSION,
    RELEASE
  } arb_state_t;

  localparam int unsigned DEF_N_CONS        = 4;
  localparam int unsigned DEF_GRANT_TIMEOUT = 1024;
  localparam int unsigned DEF_MAX_FAILS     = 3;
  localparam int unsigned DEF_LOCK_CYCLES   = 4096;

  // Ceiling log2, never less than 1 so that every counter has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((32'd1 << width) < value) width++;
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/console_lockout.sv
// Per-console failed-attempt counter and lockout timer.
// Locks the console for LOCK_CYCLES cycles once MAX_FAILS consecutive fails accumulate.
module console_lockout
  import login_arb_pkg::*;
#(
  parameter int unsigned MAX_FAILS   = DEF_MAX_FAILS,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic fail_pulse,
  input  logic success_pulse,
  output logic locked
);

  localparam int unsigned FW = clog2(MAX_FAILS + 1);
  localparam int unsigned LW = clog2(LOCK_CYCLES);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);

  logic [FW-1:0] fail_cnt;
  logic [LW-1:0] lock_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_cnt <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (locked) begin
      // Lock ends the cycle after the counter has reached zero.
      if (lock_cnt == '0) begin
        locked   <= 1'b0;
        fail_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt - LW'(1);
      end
    end else if (success_pulse) begin
      fail_cnt <= '0;
    end else if (fail_pulse && (fail_cnt != FAIL_MAX)) begin
      fail_cnt <= fail_cnt + FW'(1);
      if (fail_cnt == FAIL_MAX - FW'(1)) begin
        locked   <= 1'b1;
        lock_cnt <= LOCK_LOAD;
      end
    end
  end

endmodule

// File: rtl/login_arbiter.sv
// Round-robin arbiter sharing one AccessController among N consoles.
// Steers the owner's keypad into the controller and tracks the login session.
module login_arbiter
  import login_arb_pkg::*;
#(
  parameter int unsigned N_CONS        = DEF_N_CONS,
  parameter int unsigned GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int unsigned MAX_FAILS     = DEF_MAX_FAILS,
  parameter int unsigned LOCK_CYCLES   = DEF_LOCK_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CONS-1:0]     cons_req,
  input  logic [4*N_CONS-1:0]   cons_digit,
  input  logic [N_CONS-1:0]     cons_enter,
  input  logic [N_CONS-1:0]     cons_logout,
  output logic [N_CONS-1:0]     grant,
  output logic [N_CONS-1:0]     locked,
  output logic                  session_active,
  output logic                  owner_isguest,
  output logic [3:0]            ac_digit,
  output logic                  ac_enter,
  output logic                  ac_logout,
  input  logic                  ac_loggedin,
  input  logic                  ac_isguest
);

  localparam int unsigned PW = clog2(N_CONS);
  localparam int unsigned TW = clog2(GRANT_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(GRANT_TIMEOUT - 1);

  arb_state_t        state, state_nx;
  logic [N_CONS-1:0] grant_nx;
  logic [PW-1:0]     owner, owner_nx;
  logic [PW-1:0]     rr_ptr, rr_nx;
  logic [PW-1:0]     next_ptr;
  logic [TW-1:0]     tmo_cnt, tmo_nx;
  logic              logout_q, logout_nx;
  logic [N_CONS-1:0] fail_pulse, success_pulse;
  logic [N_CONS-1:0] eligible;
  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  int unsigned       cand;

  for (genvar i = 0; i < N_CONS; i++) begin : g_lock
    console_lockout #(
      .MAX_FAILS   (MAX_FAILS),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock (
      .clk           (clk),
      .rst           (rst),
      .fail_pulse    (fail_pulse[i]),
      .success_pulse (success_pulse[i]),
      .locked        (locked[i])
    );
  end

  assign eligible = cons_req & ~locked;
  assign next_ptr = PW'((32'(owner) + 1) % N_CONS);

  // First eligible console at or after rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < N_CONS; k++) begin
      cand = (32'(rr_ptr) + k) % N_CONS;
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    owner_nx      = owner;
    rr_nx         = rr_ptr;
    tmo_nx        = tmo_cnt;
    logout_nx     = 1'b0;
    fail_pulse    = '0;
    success_pulse = '0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nx = ENTRY;
          grant_nx = N_CONS'(1) << pick_idx;
          owner_nx = pick_idx;
          tmo_nx   = '0;
        end
      end
      ENTRY: begin
        tmo_nx = cons_enter[owner] ? '0 : tmo_cnt + TW'(1);
        if (ac_loggedin) begin
          state_nx             = SESSION;
          success_pulse[owner] = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx          = RELEASE;
          fail_pulse[owner] = 1'b1;
          logout_nx         = 1'b1;
        end else if (!cons_req[owner]) begin
          state_nx  = RELEASE;
          logout_nx = 1'b1;
        end
      end
      SESSION: begin
        if (cons_logout[owner]) begin
          state_nx  = RELEASE;
          logout_nx = 1'b1;
        end else if (!ac_loggedin) begin
          state_nx = IDLE;
          grant_nx = '0;
          rr_nx    = next_ptr;
        end
      end
      RELEASE: begin
        if (!ac_loggedin) begin
          state_nx = IDLE;
          grant_nx = '0;
          rr_nx    = next_ptr;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      tmo_cnt  <= '0;
      logout_q <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_nx;
      tmo_cnt  <= tmo_nx;
      logout_q <= logout_nx;
    end
  end

  assign session_active = (state == SESSION);
  assign owner_isguest  = session_active & ac_isguest;
  assign ac_digit       = (state == ENTRY) ? cons_digit[{owner, 2'b00} +: 4] : 4'h0;
  assign ac_enter       = (state == ENTRY) & cons_enter[owner];
  assign ac_logout      = logout_q;

endmodule
